// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: FSM states, default sizes, operand legality check.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_pkg;

    localparam int SEQ_MAX_LEN = 8;
    localparam int SEQ_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    // A length is usable only if at least one bit is sent and it fits the pattern register.
    function automatic logic len_legal(input int l, input int max_len);
        return (l >= 1) && (l <= max_len);
    endfunction

endpackage

// File: rtl/seq_shift_out.sv
// Loadable MSB-first bit shifter: holds the captured pattern/length and presents one registered bit per step.
// Latency: the bit selected by load/restart/shift appears on x the cycle after the command.
// Backpressure: none; the owner issues at most one command per cycle, and x returns to 0 on an idle cycle.
module seq_shift_out import seq_pkg::*; #(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int CNT_W   = SEQ_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               restart,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] load_pat,
    input  logic [CNT_W-1:0]   load_len,
    output logic               x,
    output logic               last
);

    logic [MAX_LEN-1:0] pat_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   idx_q;

    logic [MAX_LEN-1:0] src_pat;
    logic [CNT_W-1:0]   src_idx;
    logic               bit_nx;

    // Pick the bit to present next: top bit of a fresh load, top bit again on a repeat, else one lower.
    always_comb begin
        src_pat = pat_q;
        src_idx = idx_q - CNT_W'(1);
        bit_nx  = 1'b0;
        if (load) begin
            src_pat = load_pat;
            src_idx = load_len - CNT_W'(1);
        end else if (restart) begin
            src_idx = len_q - CNT_W'(1);
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            if (src_idx == CNT_W'(i)) begin
                bit_nx = src_pat[i];
            end
        end
    end

    // Capture operands on load; advance the bit index and the registered output bit on every command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            x     <= 1'b0;
        end else begin
            if (load) begin
                pat_q <= load_pat;
                len_q <= load_len;
            end
            if (load || restart || shift) begin
                idx_q <= src_idx;
                x     <= bit_nx;
            end else begin
                x     <= 1'b0;
            end
        end
    end

    assign last = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends len bits MSB-first, rpt+1 times, with gap idle cycles between repeats.
// Latency: first bit on x one cycle after start is sampled; done pulses the cycle after the last bit.
// Backpressure: none; start is only looked at in IDLE and ignored while busy.
module seq_pattern_gen import seq_pkg::*; #(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int CNT_W   = SEQ_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   len,
    input  logic [CNT_W-1:0]   rpt,
    input  logic [CNT_W-1:0]   gap,
    output logic               x,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    seq_state_e       state, state_nx;
    logic [CNT_W-1:0] rpt_cnt, rpt_nx;
    logic [CNT_W-1:0] gap_cnt, gap_nx;
    logic [CNT_W-1:0] gap_q, gap_q_nx;
    logic             done_nx, err_nx;
    logic             sh_load, sh_restart, sh_shift;
    logic             sh_last;

    seq_shift_out #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .restart  (sh_restart),
        .shift    (sh_shift),
        .load_pat (pattern),
        .load_len (len),
        .x        (x),
        .last     (sh_last)
    );

    // Next-state, shifter commands and counter updates; rpt_cnt counts repeats still owed after the current one.
    always_comb begin
        state_nx   = state;
        rpt_nx     = rpt_cnt;
        gap_nx     = gap_cnt;
        gap_q_nx   = gap_q;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        sh_load    = 1'b0;
        sh_restart = 1'b0;
        sh_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_legal(int'(len), MAX_LEN)) begin
                        sh_load  = 1'b1;
                        rpt_nx   = rpt;
                        gap_q_nx = gap;
                        state_nx = SEND;
                    end else begin
                        err_nx   = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!sh_last) begin
                    sh_shift = 1'b1;
                end else if (rpt_cnt != '0) begin
                    rpt_nx = rpt_cnt - CNT_W'(1);
                    if (gap_q != '0) begin
                        gap_nx   = gap_q - CNT_W'(1);
                        state_nx = GAP;
                    end else begin
                        sh_restart = 1'b1;
                    end
                end else begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    sh_restart = 1'b1;
                    state_nx   = SEND;
                end else begin
                    gap_nx = gap_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rpt_cnt <= '0;
            gap_cnt <= '0;
            gap_q   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            rpt_cnt <= rpt_nx;
            gap_cnt <= gap_nx;
            gap_q   <= gap_q_nx;
            valid   <= (state_nx == SEND);
            busy    <= (state_nx != IDLE);
            done    <= done_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the len, rpt and gap fields.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 SHALL have port pattern  input  MAX_LEN  bits to send; bit len-1 is sent first, bit 0 last.
REQ-007 SHALL have port len  input  CNT_W  pattern length; legal range 1..MAX_LEN.
REQ-008 SHALL have port rpt  input  CNT_W  extra repetitions; total repetitions = rpt+1.
REQ-009 SHALL have port gap  input  CNT_W  idle cycles inserted between repetitions.
REQ-010 SHALL have port x  output  1  serial data bit, registered.
REQ-011 SHALL have port valid  output  1  x carries a pattern bit this cycle.
REQ-012 SHALL have port busy  output  1  transmission in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the final bit.
REQ-014 SHALL have port err  output  1  one-cycle pulse on an illegal start request.

Function
REQ-015 SHALL implement Moore FSM states IDLE, SEND, GAP; all outputs registered and driven from state/counters only.
REQ-016 In IDLE with start=1 and 1<=len<=MAX_LEN, SHALL capture pattern, len, rpt and gap, then enter SEND.
REQ-017 The first bit SHALL appear on x with valid=1 in the cycle after start is sampled; latency is 1 cycle.
REQ-018 In SEND, SHALL emit one bit per cycle from bit len-1 down to bit 0, with valid=1 and busy=1.
REQ-019 After bit 0 with repetitions remaining and gap>0, SHALL enter GAP for exactly gap cycles (x=0, valid=0, busy=1), then return to SEND.
REQ-020 After bit 0 with repetitions remaining and gap=0, SHALL restart at bit len-1 in the next cycle, with no bubble.
REQ-021 After bit 0 of the final repetition, SHALL return to IDLE and pulse done=1 for exactly one cycle (the cycle after the last bit).
REQ-022 In IDLE, SHALL drive x=0, valid=0 and busy=0.
REQ-023 SHALL ignore start while busy=1; the captured operands SHALL NOT change mid-transmission.
REQ-024 In IDLE with start=1 and len=0 or len>MAX_LEN, SHALL stay in IDLE and pulse err=1 for one cycle; no bits are sent.
REQ-025 Start asserted in the same cycle done is high SHALL be accepted, allowing back-to-back transmissions.
REQ-026 Bit index, repetition and gap counters SHALL be CNT_W bits wide and SHALL NOT wrap; rpt=2^CNT_W-1 yields 2^CNT_W repetitions.
REQ-027 Pattern bits above len-1 SHALL be ignored.

Reset
REQ-028 While reset=0, SHALL force state IDLE, x=0, valid=0, busy=0, done=0, err=0, and clear all counters and captured operands.
REQ-029 Reset asserted mid-transmission SHALL abort immediately (asynchronously), without a done pulse.
REQ-030 After reset deasserts, the first start SHALL be honoured on the first rising clk edge.

Structure
REQ-031 State encoding constants (IDLE, SEND, GAP) and MAX_LEN/CNT_W defaults SHALL live in a shared package, seq_pkg.
REQ-032 A sub-module seq_shift_out (loadable MSB-first shift register with bit counter) SHALL be used; the FSM and repetition/gap counters stay in the top level.

Verification
REQ-033 pattern=0110, len=4, rpt=0, gap=0, start pulse -> x=0,1,1,0 with valid=1 in cycles 1-4; done=1 in cycle 5; busy=0 in cycle 5.
REQ-034 pattern=101, len=3, rpt=1, gap=2 -> x/valid = 1,0,1 | 0/0,0/0 | 1,0,1; single done pulse afterward.
REQ-035 pattern=0110, len=4, rpt=2, gap=0 -> 12 contiguous valid bits 011001100110; start pulsed mid-stream -> ignored.
REQ-036 start with len=0, then with len=9 (MAX_LEN=8) -> err pulses once per request; busy, valid and done stay 0.
REQ-037 reset=0 asserted at bit 2 of a transmission -> all outputs 0 at once, no done pulse; a new start after release sends the full pattern.
REQ-038 start held high across done -> second transmission's first bit appears in the cycle after done, with no idle gap.
